// File: rtl/exotiny_rst_seq_if.sv
// Pin bundle between the reset sequencer and its surroundings: raw PLL lock
// and button in, staggered resets and debug status out.
interface exotiny_rst_seq_if #(
  parameter int LOSS_W = 4
);
  logic              pll_locked_i;
  logic              btn_rst_i;
  logic              rst_mem_no;
  logic              rst_core_no;
  logic              led_rst_n;
  logic              run_o;
  logic [LOSS_W-1:0] loss_cnt_o;

  // Board / bench side: drives the raw inputs, observes the resets.
  modport master (
    output pll_locked_i, btn_rst_i,
    input  rst_mem_no, rst_core_no, led_rst_n, run_o, loss_cnt_o
  );

  // Sequencer side.
  modport slave (
    input  pll_locked_i, btn_rst_i,
    output rst_mem_no, rst_core_no, led_rst_n, run_o, loss_cnt_o
  );
endinterface

// File: rtl/exotiny_rst_seq.sv
// Reset sequencer for the ExoTiny SoC wrapper. Synchronises PLL lock and the
// user button, debounces the button, waits for stable lock, then releases the
// QSPI memory reset followed by the core reset. Counts lock-loss events.
module exotiny_rst_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_CYC   = 1024,
  parameter int HOLD_CYCLES    = 255,
  parameter int STAGGER_CYCLES = 16,
  parameter int LOSS_W         = 4
) (
  input  logic               clk_i,
  input  logic               rst_in,
  exotiny_rst_seq_if.slave   bus
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_MEM, S_RUN} state_t;

  logic [SYNC_STAGES-1:0] lock_sync, btn_sync;
  logic                   lock_s, btn_s, lock_s_q;
  logic                   btn_db;
  logic [DB_W-1:0]        db_cnt;
  logic [LOSS_W-1:0]      loss_cnt;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   mem_q, core_q, run_q;
  logic                   mem_d, core_d, run_d;
  logic                   abort;

  assign lock_s = lock_sync[SYNC_STAGES-1];
  assign btn_s  = btn_sync[SYNC_STAGES-1];
  assign abort  = !lock_s || btn_db;

  // Input synchroniser chains; raw pins are only ever seen by stage 0.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      lock_sync <= '0;
      btn_sync  <= '0;
      lock_s_q  <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], bus.btn_rst_i};
      lock_s_q  <= lock_s;
    end
  end

  // Button debounce: the counter records how many consecutive cycles btn_s has
  // disagreed with btn_db; once DEBOUNCE_CYC such cycles are on record, the
  // next still-disagreeing cycle flips btn_db. Any agreeing cycle restarts it.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYC)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Saturating lock-loss counter on the synchronised falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_in)
      loss_cnt <= '0;
    else if (lock_s_q && !lock_s && !(&loss_cnt))
      loss_cnt <= loss_cnt + 1'b1;
  end

  // Sequencer state, cycle counter and registered reset outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      mem_q   <= 1'b0;
      core_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      core_q  <= core_d;
      run_q   <= run_d;
    end
  end

  // Next state; abort is checked before the terminal count so a late abort
  // never advances. Outputs decode the next state, so resets and state switch
  // on the same edge and core can never be out of reset without memory.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = '0;
        if (lock_s && !btn_db) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (abort) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = S_MEM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MEM: begin
        if (abort) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (abort) state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
    endcase
    mem_d  = (state_d == S_MEM) || (state_d == S_RUN);
    core_d = (state_d == S_RUN);
    run_d  = (state_d == S_RUN);
  end

  assign bus.rst_mem_no  = mem_q;
  assign bus.rst_core_no = core_q;
  assign bus.led_rst_n   = core_q;
  assign bus.run_o       = run_q;
  assign bus.loss_cnt_o  = loss_cnt;

endmodule
